// File: rtl/dmem_word_port.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_word_port
//  Purpose  : Parametrised single-port data memory behind a valid/ready
//             request channel. Responses come from a one-entry output
//             register and honour consumer backpressure. Byte-enable writes
//             are supported. Misaligned or out-of-range accesses leave the
//             storage untouched and return an error response.
//  Ports    : clk        rising-edge clock
//             reset      asynchronous active-high reset
//             req_valid/req_ready/req_write/req_addr/req_wdata/req_be
//                        request channel (accepted when valid && ready)
//             rsp_valid/rsp_ready/rsp_rdata/rsp_err
//                        response channel (consumed when valid && ready)
//             err_count  saturating count of error responses issued
//  Revision : 1.0  initial release
// ============================================================================
module dmem_word_port #(
  parameter int          DW    = 32,
  parameter int          AW    = 32,
  parameter int          DEPTH = 1024,
  parameter int unsigned BASE  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic [15:0]     err_count
);

  localparam int            NB     = DW / 8;
  localparam int            OFFW   = $clog2(NB);
  localparam int            IW     = $clog2(DEPTH);
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  // Storage array: deliberately not reset, contents survive reset.
  logic [DW-1:0] mem_q [DEPTH];

  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q,   rsp_err_d;
  logic [15:0]   err_count_q, err_count_d;

  logic          w_aligned;
  logic          w_above_base;
  logic [AW-1:0] w_addr_off;
  logic [AW-1:0] w_word_off;
  logic          w_in_range;
  logic          w_ok;
  logic [IW-1:0] w_idx;
  logic          w_accept;
  logic          w_mem_we;

  // Byte offset bits only exist when a word is wider than one byte.
  generate
    if (OFFW == 0) begin : g_byte_word
      assign w_aligned = 1'b1;
    end else begin : g_multi_byte_word
      assign w_aligned = (req_addr[OFFW-1:0] == '0);
    end
  endgenerate

  // Range check: any bit of the word offset above the index width means
  // the address falls past the last word.
  assign w_above_base = (req_addr >= BASE_A);
  assign w_addr_off   = req_addr - BASE_A;
  assign w_word_off   = w_addr_off >> OFFW;
  assign w_in_range   = w_above_base && ((w_word_off >> IW) == '0);
  assign w_idx        = w_word_off[IW-1:0];
  assign w_ok         = w_aligned && w_in_range;

  // One-entry output register: a slot frees up in the same cycle the
  // consumer takes the current response, so continuous flow has no bubble.
  assign req_ready = !rsp_valid_q || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  // A request presented while reset is asserted must not touch storage.
  assign w_mem_we  = w_accept && w_ok && req_write && !reset;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          mem_q[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
    if (w_accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !w_ok;
      rsp_rdata_d = (w_ok && !req_write) ? mem_q[w_idx] : '0;
      // Counted at acceptance, not when the error response is consumed.
      if (!w_ok && (err_count_q != 16'hFFFF)) begin
        err_count_d = err_count_q + 16'd1;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_word_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_word_port
//  Purpose  : Directed self-checking bench for dmem_word_port. Instance A
//             uses default parameters; instance B uses DW=64, DEPTH=16,
//             BASE=256.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_word_port;

  logic clk;
  logic reset;

  logic        a_req_valid, a_req_ready, a_req_write;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_be;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic [15:0] a_err_count;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic [7:0]  b_req_be;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [63:0] b_rsp_rdata;
  logic [15:0] b_err_count;

  int checks   = 0;
  int failures = 0;

  dmem_word_port u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_write (a_req_write),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .req_be    (a_req_be),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (a_rsp_ready),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err),
    .err_count (a_err_count)
  );

  dmem_word_port #(.DW(64), .AW(32), .DEPTH(16), .BASE(256)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_write (b_req_write),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_be    (b_req_be),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err),
    .err_count (b_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one request on instance A (b=0) or B (b=1), wait (bounded) for
  // ready, let it be accepted on the next edge, then drop valid. Returns
  // #1 after the accepting edge.
  task automatic issue(input bit b, input bit w, input logic [31:0] addr,
                       input logic [63:0] data, input logic [7:0] be);
    int n;
    if (!b) begin
      a_req_valid = 1'b1; a_req_write = w; a_req_addr = addr;
      a_req_wdata = data[31:0]; a_req_be = be[3:0];
    end else begin
      b_req_valid = 1'b1; b_req_write = w; b_req_addr = addr;
      b_req_wdata = data; b_req_be = be;
    end
    n = 0;
    while (!(b ? b_req_ready : a_req_ready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("req_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input bit b, input bit err,
                            input logic [63:0] rdata);
    check({tag, "_valid"}, b ? 64'(b_rsp_valid) : 64'(a_rsp_valid), 64'd1);
    check({tag, "_err"},   b ? 64'(b_rsp_err)   : 64'(a_rsp_err),   64'(err));
    check({tag, "_rdata"}, b ? b_rsp_rdata      : 64'(a_rsp_rdata), rdata);
  endtask

  initial begin
    reset       = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0;
    a_req_wdata = '0;   a_req_be = '0;      a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0;
    b_req_wdata = '0;   b_req_be = '0;      b_rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    check("rst_rsp_err",   64'(a_rsp_err),   64'd0);
    check("rst_rsp_rdata", 64'(a_rsp_rdata), 64'd0);
    check("rst_err_count", 64'(a_err_count), 64'd0);
    check("rst_req_ready", 64'(a_req_ready), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // ---------------- basic writes / reads, instance A ----------------
    issue(0, 1, 32'd16, 64'h12345678, 8'hF);
    expect_rsp("wr16", 0, 0, 64'd0);
    issue(0, 1, 32'd24, 64'h89abcdef, 8'hF);
    expect_rsp("wr24", 0, 0, 64'd0);
    issue(0, 0, 32'd16, 64'd0, 8'h0);
    expect_rsp("rd16", 0, 0, 64'h12345678);
    issue(0, 0, 32'd24, 64'd0, 8'h0);
    expect_rsp("rd24", 0, 0, 64'h89abcdef);
    @(posedge clk); #1;
    check("drain_valid", 64'(a_rsp_valid), 64'd0);

    // Last word of the array.
    issue(0, 1, 32'd4092, 64'hDEADBEEF, 8'hF);
    expect_rsp("wr_last", 0, 0, 64'd0);
    issue(0, 0, 32'd4092, 64'd0, 8'h0);
    expect_rsp("rd_last", 0, 0, 64'hDEADBEEF);

    // ---------------- byte enables ----------------
    issue(0, 1, 32'd16, 64'hAABBCCDD, 8'h5);
    expect_rsp("wr_be", 0, 0, 64'd0);
    issue(0, 0, 32'd16, 64'd0, 8'h0);
    expect_rsp("rd_be", 0, 0, 64'h12BB56DD);

    // Zero byte-enable write is a no-op with a normal response.
    issue(0, 1, 32'd24, 64'h0, 8'h0);
    expect_rsp("wr_be0", 0, 0, 64'd0);
    issue(0, 0, 32'd24, 64'd0, 8'h0);
    expect_rsp("rd_be0", 0, 0, 64'h89abcdef);

    // ---------------- errors ----------------
    issue(0, 0, 32'd18, 64'd0, 8'h0);
    expect_rsp("rd_misal", 0, 1, 64'd0);
    check("errcnt1", 64'(a_err_count), 64'd1);
    issue(0, 1, 32'd4096, 64'hFFFFFFFF, 8'hF);
    expect_rsp("wr_oor", 0, 1, 64'd0);
    check("errcnt2", 64'(a_err_count), 64'd2);
    issue(0, 0, 32'd16, 64'd0, 8'h0);
    expect_rsp("rd_after_err", 0, 0, 64'h12BB56DD);
    issue(0, 0, 32'd0, 64'd0, 8'h0);   // word 4096/4 wrapped onto index 0 must be untouched
    check("errcnt_stable", 64'(a_err_count), 64'd2);
    @(posedge clk); #1;

    // ---------------- backpressure ----------------
    a_rsp_ready = 1'b0;
    issue(0, 0, 32'd16, 64'd0, 8'h0);
    expect_rsp("bp_first", 0, 0, 64'h12BB56DD);
    check("bp_ready_low", 64'(a_req_ready), 64'd0);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'd24;
    repeat (2) @(posedge clk);
    #1;
    expect_rsp("bp_held", 0, 0, 64'h12BB56DD);
    check("bp_ready_still_low", 64'(a_req_ready), 64'd0);
    a_rsp_ready = 1'b1;
    #1;
    check("bp_ready_rise", 64'(a_req_ready), 64'd1);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    expect_rsp("bp_second", 0, 0, 64'h89abcdef);
    @(posedge clk); #1;
    check("bp_drained", 64'(a_rsp_valid), 64'd0);

    // Stalled write must not modify storage.
    a_rsp_ready = 1'b0;
    issue(0, 0, 32'd24, 64'd0, 8'h0);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'd16;
    a_req_wdata = 32'h0; a_req_be = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    issue(0, 0, 32'd16, 64'd0, 8'h0);
    expect_rsp("stall_wr_blocked", 0, 0, 64'h12BB56DD);
    @(posedge clk); #1;

    // ---------------- reset mid-operation ----------------
    a_rsp_ready = 1'b0;
    issue(0, 0, 32'd18, 64'd0, 8'h0);   // pending error response, count 3
    check("pre_rst_cnt", 64'(a_err_count), 64'd3);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'd24;
    a_req_wdata = 32'h0; a_req_be = 4'hF;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(a_rsp_valid), 64'd0);
    check("mid_rst_cnt",   64'(a_err_count), 64'd0);
    check("mid_rst_err",   64'(a_rsp_err),   64'd0);
    check("mid_rst_ready", 64'(a_req_ready), 64'd1);
    @(posedge clk); #1;                 // write presented during reset
    a_req_valid = 1'b0;
    reset = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    issue(0, 0, 32'd24, 64'd0, 8'h0);
    expect_rsp("post_rst_rd24", 0, 0, 64'h89abcdef);
    issue(0, 0, 32'd16, 64'd0, 8'h0);
    expect_rsp("post_rst_rd16", 0, 0, 64'h12BB56DD);
    @(posedge clk); #1;

    // ---------------- instance B: DW=64, DEPTH=16, BASE=256 ----------------
    issue(1, 1, 32'd264, 64'h11111111_22222222, 8'hFF);
    expect_rsp("b_wr_full", 1, 0, 64'd0);
    issue(1, 1, 32'd264, 64'hAAAAAAAA_BBBBBBBB, 8'hF0);
    expect_rsp("b_wr_upper", 1, 0, 64'd0);
    issue(1, 0, 32'd264, 64'd0, 8'h0);
    expect_rsp("b_rd_upper", 1, 0, 64'hAAAAAAAA_22222222);
    issue(1, 1, 32'd376, 64'h01234567_89ABCDEF, 8'hFF);
    expect_rsp("b_wr_last", 1, 0, 64'd0);
    issue(1, 0, 32'd376, 64'd0, 8'h0);
    expect_rsp("b_rd_last", 1, 0, 64'h01234567_89ABCDEF);
    issue(1, 0, 32'd260, 64'd0, 8'h0);
    expect_rsp("b_misal", 1, 1, 64'd0);
    issue(1, 0, 32'd384, 64'd0, 8'h0);
    expect_rsp("b_past_end", 1, 1, 64'd0);
    issue(1, 0, 32'd248, 64'd0, 8'h0);
    expect_rsp("b_below_base", 1, 1, 64'd0);
    check("b_errcnt", 64'(b_err_count), 64'd3);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
